// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic light controller.
//   state_t  : phase state machine encoding
//   LAMP_*   : {R,Y,G} one-hot lamp codes
//   ns_lamp / ew_lamp / is_ped : per-state output decode helpers
package traffic_pkg;

    typedef enum logic [2:0] {
        RED_TO_NS,
        NS_GREEN,
        NS_YELLOW,
        RED_TO_EW,
        EW_GREEN,
        EW_YELLOW,
        PED_TO_NS,
        PED_TO_EW
    } state_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            NS_GREEN:  ns_lamp = LAMP_G;
            NS_YELLOW: ns_lamp = LAMP_Y;
            default:   ns_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            EW_GREEN:  ew_lamp = LAMP_G;
            EW_YELLOW: ew_lamp = LAMP_Y;
            default:   ew_lamp = LAMP_R;
        endcase
    endfunction

    function automatic logic is_ped(input state_t s);
        is_ped = (s == PED_TO_NS) || (s == PED_TO_EW);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: emits a one-cycle tick every TICKS_PER_SEC clocks.
//   clk     : system clock
//   rst     : synchronous active-high reset (count -> 0)
//   restart : synchronous restart of the count at 0
//   tick    : registered one-cycle pulse while the count sits at TICKS_PER_SEC-1
module sec_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned      CNT_W   = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_tick;

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (restart || (r_cnt == CNT_MAX)) begin
            w_cnt_next = '0;
        end
    end

    // tick is registered against the next count so it lines up with the
    // cycle in which r_cnt holds CNT_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (w_cnt_next == CNT_MAX);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection sequencer with a pedestrian walk phase.
//   clk, rst   : system clock, synchronous active-high reset
//   ped_req    : synchronised pedestrian button
//   ped_ack    : one-cycle pulse on entry to a walk phase
//   ns_light   : north-south lamps {R,Y,G}
//   ew_light   : east-west lamps {R,Y,G}
//   walk       : walk lamp
//   countdown  : whole seconds left in the current phase (never 0)
//   tick       : one-cycle seconds pulse
//
// state     | meaning
// RED_TO_NS | all red, next is NS green (or walk if requested)
// NS_GREEN  | ns green, ew red
// NS_YELLOW | ns yellow, ew red
// RED_TO_EW | all red, next is EW green (or walk if requested)
// EW_GREEN  | ew green, ns red
// EW_YELLOW | ew yellow, ns red
// PED_TO_NS | all red with walk, then NS green
// PED_TO_EW | all red with walk, then EW green
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned GREEN_S       = 20,
    parameter int unsigned YELLOW_S      = 3,
    parameter int unsigned ALL_RED_S     = 2,
    parameter int unsigned WALK_S        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] countdown,
    output logic       tick
);

    state_t     r_state;
    state_t     w_state_next;
    logic       w_tick;
    logic       w_advance;
    logic       w_ped_entry;
    logic [7:0] r_countdown;
    logic       r_pending;
    logic       r_ped_ack;
    logic [2:0] r_ns_light;
    logic [2:0] r_ew_light;
    logic       r_walk;

    function automatic logic [7:0] phase_len(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = 8'(GREEN_S);
            NS_YELLOW, EW_YELLOW: phase_len = 8'(YELLOW_S);
            PED_TO_NS, PED_TO_EW: phase_len = 8'(WALK_S);
            default:              phase_len = 8'(ALL_RED_S);
        endcase
    endfunction

    // A phase ends only on the tick that would take countdown from 1 to 0,
    // so the prescaler wraps in the same cycle and the restart just pins it.
    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_advance),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_advance    = w_tick && (r_countdown == 8'd1);
        if (w_advance) begin
            case (r_state)
                RED_TO_NS: w_state_next = r_pending ? PED_TO_NS : NS_GREEN;
                PED_TO_NS: w_state_next = NS_GREEN;
                NS_GREEN:  w_state_next = NS_YELLOW;
                NS_YELLOW: w_state_next = RED_TO_EW;
                RED_TO_EW: w_state_next = r_pending ? PED_TO_EW : EW_GREEN;
                PED_TO_EW: w_state_next = EW_GREEN;
                EW_GREEN:  w_state_next = EW_YELLOW;
                EW_YELLOW: w_state_next = RED_TO_NS;
                default:   w_state_next = RED_TO_NS;
            endcase
        end
    end

    assign w_ped_entry = w_advance && is_ped(w_state_next);

    // Outputs are decoded from the next state so lamps and countdown move on
    // the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RED_TO_NS;
            r_countdown <= 8'(ALL_RED_S);
            r_pending   <= 1'b0;
            r_ped_ack   <= 1'b0;
            r_ns_light  <= LAMP_R;
            r_ew_light  <= LAMP_R;
            r_walk      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ns_light <= ns_lamp(w_state_next);
            r_ew_light <= ew_lamp(w_state_next);
            r_walk     <= is_ped(w_state_next);
            r_ped_ack  <= w_ped_entry;
            if (w_advance) begin
                r_countdown <= phase_len(w_state_next);
            end else if (w_tick) begin
                r_countdown <= r_countdown - 8'd1;
            end
            // Serving a request beats a press landing in the same cycle.
            if (w_ped_entry) begin
                r_pending <= 1'b0;
            end else if (ped_req && !is_ped(r_state)) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign ped_ack   = r_ped_ack;
    assign ns_light  = r_ns_light;
    assign ew_light  = r_ew_light;
    assign walk      = r_walk;
    assign countdown = r_countdown;
    assign tick      = w_tick;

endmodule
